// File: rtl/seq_det_ctrl.sv
// Run controller for the serial "111" detector: arms it for a window of cycles,
// counts detect pulses and reports HIT (threshold reached) or MISS (window expired).
module seq_det_ctrl #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic [CNT_W-1:0] cfg_threshold,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             det,
    output logic             det_en,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_RUN    | detector armed, counting detects, window timer running
    // S_REPORT | result held (done=1) until ack or abort
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_REPORT = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating count including this cycle's detect pulse.
    assign cnt_inc = (det && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        win_d   = win_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    thr_d   = cfg_threshold;
                    win_d   = cfg_window;
                    cnt_d   = '0;
                    timer_d = '0;
                    if (cfg_threshold == '0) begin
                        state_d = S_REPORT;
                        hit_d   = 1'b1;
                    end else if (cfg_window == '0) begin
                        state_d = S_REPORT;
                        hit_d   = 1'b0;
                    end else begin
                        state_d = S_RUN;
                        hit_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    hit_d   = 1'b0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + WIN_W'(1);
                    cnt_d   = cnt_inc;
                    // Threshold beats expiry when both land on the last cycle.
                    if (cnt_inc >= thr_q) begin
                        state_d = S_REPORT;
                        hit_d   = 1'b1;
                    end else if (timer_d == win_q) begin
                        state_d = S_REPORT;
                        hit_d   = 1'b0;
                    end
                end
            end
            S_REPORT: begin
                if (abort || ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                hit_d   = 1'b0;
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            thr_q   <= '0;
            win_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            win_q   <= win_d;
            timer_q <= timer_d;
        end
    end

    assign det_en    = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_REPORT);
    assign hit       = hit_q;
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: stimulus queues expected results, a monitor
// pops and compares on every rising edge of done.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, ack, det;
    logic [7:0]  cfg_threshold;
    logic [15:0] cfg_window;
    logic        det_en, busy, done, hit;
    logic [7:0]  hit_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       hit;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    seq_det_ctrl #(.CNT_W(8), .WIN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .cfg_threshold(cfg_threshold), .cfg_window(cfg_window), .det(det),
        .det_en(det_en), .busy(busy), .done(done), .hit(hit), .hit_count(hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the reported result and the cycle done rises.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_hit", int'(hit), int'(e.hit));
                chk("sb_count", int'(hit_count), int'(e.cnt));
                chk("sb_done_cycle", cyc, e.cyc);
            end
        end
        done_prev <= done;
    end

    // Launch a run, drive det per mask over run cycles 1..ncyc, then acknowledge.
    task automatic do_run(input int thr, input int win, input logic [63:0] mask,
                          input int ncyc, input bit exp_hit, input int exp_cnt,
                          input int exp_d, input bit use_abort);
        exp_t e;
        int n;
        @(negedge clk);
        cfg_threshold = 8'(thr);
        cfg_window    = 16'(win);
        start = 1'b1;
        det   = 1'b0;
        e.hit = exp_hit;
        e.cnt = 8'(exp_cnt);
        e.cyc = cyc + 1 + exp_d;
        sb_q.push_back(e);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            det   = mask[k];
        end
        @(negedge clk);
        start = 1'b0;
        det   = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done), 1);
        if (use_abort) abort = 1'b1;
        else           ack   = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ack   = 1'b0;
        chk("done_cleared", int'(done), 0);
        chk("idle_after_ack", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; det = 1'b0;
        cfg_threshold = '0; cfg_window = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_det_en", int'(det_en), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_count", int'(hit_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // det in IDLE must not be counted by the following run
        det = 1'b1;
        @(negedge clk);
        det = 1'b0;

        // T1: thr=3 win=20, det at 4,5,6 -> early HIT, decided at edge 6
        m = '0; m[4] = 1'b1; m[5] = 1'b1; m[6] = 1'b1;
        do_run(3, 20, m, 6, 1'b1, 3, 6, 1'b0);

        // T2: thr=3 win=10, det at 2 and 9 -> MISS at edge 10
        m = '0; m[2] = 1'b1; m[9] = 1'b1;
        do_run(3, 10, m, 10, 1'b0, 2, 10, 1'b0);

        // T3: thr=2 win=5, det at 1 and 5 (last cycle) -> HIT
        m = '0; m[1] = 1'b1; m[5] = 1'b1;
        do_run(2, 5, m, 5, 1'b1, 2, 5, 1'b0);

        // T4: zero threshold -> immediate HIT; zero window -> immediate MISS
        m = '0;
        do_run(0, 7, m, 0, 1'b1, 0, 0, 1'b0);
        do_run(4, 0, m, 0, 1'b0, 0, 0, 1'b1);

        // Window of 1 with no detects -> MISS at edge 1
        do_run(2, 1, m, 1, 1'b0, 0, 1, 1'b0);

        // T5: abort at run cycle 3 while det is active
        @(negedge clk);
        cfg_threshold = 8'd3; cfg_window = 16'd20; start = 1'b1;
        @(negedge clk); start = 1'b0; det = 1'b1;
        chk("t5_det_en", int'(det_en), 1);
        @(negedge clk); det = 1'b1;
        @(negedge clk); det = 1'b1; abort = 1'b1;
        @(negedge clk); det = 1'b0; abort = 1'b0;
        chk("t5_busy_after_abort", int'(busy), 0);
        chk("t5_done_after_abort", int'(done), 0);
        repeat (4) @(negedge clk);
        chk("t5_done_stays_low", int'(done), 0);
        m = '0; m[2] = 1'b1;
        do_run(1, 3, m, 2, 1'b1, 1, 2, 1'b0);

        // T6: reset mid-run drops outputs asynchronously
        @(negedge clk);
        cfg_threshold = 8'd5; cfg_window = 16'd20; start = 1'b1;
        @(negedge clk); start = 1'b0; det = 1'b1;
        @(negedge clk); det = 1'b1;
        @(negedge clk); det = 1'b0;
        chk("t6_busy_before_rst", int'(busy), 1);
        chk("t6_count_before_rst", int'(hit_count), 2);
        #2 reset = 1'b1;
        #1;
        chk("t6_busy_async", int'(busy), 0);
        chk("t6_det_en_async", int'(det_en), 0);
        chk("t6_count_async", int'(hit_count), 0);
        chk("t6_done_async", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // T6b: start in REPORT is ignored, ack returns to IDLE next edge
        begin
            exp_t e;
            cfg_threshold = 8'd0; cfg_window = 16'd4; start = 1'b1;
            e.hit = 1'b1; e.cnt = 8'd0; e.cyc = cyc + 1;
            sb_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            chk("t6b_done", int'(done), 1);
            cfg_threshold = 8'd9; cfg_window = 16'd9; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("t6b_done_held", int'(done), 1);
            chk("t6b_hit_held", int'(hit), 1);
            chk("t6b_busy_low", int'(busy), 0);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("t6b_done_dropped", int'(done), 0);
            repeat (3) @(negedge clk);
            chk("t6b_no_relatch", int'(busy), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
